// File: rtl/pc_fetch_stage_pkg.sv
// Shared constants, select encodings and helpers for the MIPS instruction-fetch stage.
package pc_fetch_stage_pkg;

  localparam int unsigned CSIZE_DEF = 31;
  localparam int unsigned ISIZE_DEF = 31;
  localparam int unsigned CNT_W     = 16;

  localparam logic [CSIZE_DEF:0] RESET_PC_DEF = 32'h0000_0000;
  // sll $0,$0,0 encodes as the all-zero word
  localparam logic [ISIZE_DEF:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [CNT_W-1:0]   CNT_MAX      = 16'hFFFF;

  typedef enum logic [1:0] {
    PC_SEL_PLUS   = 2'b00,
    PC_SEL_HOLD   = 2'b01,
    PC_SEL_BRANCH = 2'b10,
    PC_SEL_JUMP   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    IFID_CAPTURE = 2'b00,
    IFID_HOLD    = 2'b01,
    IFID_BUBBLE  = 2'b10
  } ifid_op_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: squash inserts a bubble (beats stall), stall holds, else capture.
module pc_fetch_stage_ifid_reg
  import pc_fetch_stage_pkg::*;
#(
  parameter int unsigned CSIZE = CSIZE_DEF,
  parameter int unsigned ISIZE = ISIZE_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             squash_i,
  input  logic [ISIZE:0]   instr_i,
  input  logic [CSIZE:0]   pcplus_i,
  output logic [ISIZE:0]   instr_o,
  output logic [CSIZE:0]   pcplus_o,
  output logic             valid_o
);

  localparam logic [ISIZE:0] NOP        = NOP_INSTR;
  localparam logic [CSIZE:0] PCPLUS_CLR = {(CSIZE+1){1'b0}};

  ifid_op_e         op_s;
  logic [ISIZE:0]   instr_d, instr_q;
  logic [CSIZE:0]   pcplus_d, pcplus_q;
  logic             valid_d, valid_q;

  // Operation select
  always_comb begin
    op_s = IFID_CAPTURE;
    if (squash_i) begin
      op_s = IFID_BUBBLE;
    end else if (stall_i) begin
      op_s = IFID_HOLD;
    end else begin
      op_s = IFID_CAPTURE;
    end
  end

  // Next-state contents for the selected operation
  always_comb begin
    instr_d  = instr_q;
    pcplus_d = pcplus_q;
    valid_d  = valid_q;
    case (op_s)
      IFID_BUBBLE: begin
        instr_d  = NOP;
        pcplus_d = PCPLUS_CLR;
        valid_d  = 1'b0;
      end
      IFID_HOLD: begin
        instr_d  = instr_q;
        pcplus_d = pcplus_q;
        valid_d  = valid_q;
      end
      IFID_CAPTURE: begin
        instr_d  = instr_i;
        pcplus_d = pcplus_i;
        valid_d  = 1'b1;
      end
      default: begin
        instr_d  = NOP;
        pcplus_d = PCPLUS_CLR;
        valid_d  = 1'b0;
      end
    endcase
  end

  // IF/ID state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instr_q  <= NOP;
      pcplus_q <= PCPLUS_CLR;
      valid_q  <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      pcplus_q <= pcplus_d;
      valid_q  <= valid_d;
    end
  end

  assign instr_o  = instr_q;
  assign pcplus_o = pcplus_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and redirect counter.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int unsigned    CSIZE    = CSIZE_DEF,
  parameter int unsigned    ISIZE    = ISIZE_DEF,
  parameter logic [CSIZE:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [CSIZE:0]    branch_target,
  input  logic              jump,
  input  logic [CSIZE:0]    jump_target,
  input  logic [CSIZE:0]    pc_plus_in,
  input  logic [ISIZE:0]    imem_rdata,
  output logic [CSIZE:0]    pc_out,
  output logic [ISIZE:0]    ifid_instr,
  output logic [CSIZE:0]    ifid_pcplus,
  output logic              ifid_valid,
  output logic [CNT_W-1:0]  redirect_cnt
);

  logic             redirect_s;
  logic             squash_s;
  pc_sel_e          pc_sel_s;
  logic [CSIZE:0]   pc_d, pc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign redirect_s = jump | branch_taken;
  assign squash_s   = flush | redirect_s;

  // Next-PC source priority: jump, branch, stall hold, sequential
  always_comb begin
    pc_sel_s = PC_SEL_PLUS;
    if (jump) begin
      pc_sel_s = PC_SEL_JUMP;
    end else if (branch_taken) begin
      pc_sel_s = PC_SEL_BRANCH;
    end else if (stall) begin
      pc_sel_s = PC_SEL_HOLD;
    end else begin
      pc_sel_s = PC_SEL_PLUS;
    end
  end

  // Next-PC mux
  always_comb begin
    pc_d = pc_plus_in;
    case (pc_sel_s)
      PC_SEL_JUMP:   pc_d = jump_target;
      PC_SEL_BRANCH: pc_d = branch_target;
      PC_SEL_HOLD:   pc_d = pc_q;
      PC_SEL_PLUS:   pc_d = pc_plus_in;
      default:       pc_d = pc_plus_in;
    endcase
  end

  // Redirect counter next state
  always_comb begin
    cnt_d = cnt_q;
    if (redirect_s) begin
      cnt_d = sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // PC and counter registers; reset discards any concurrent redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= 16'h0000;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  pc_fetch_stage_ifid_reg #(
    .CSIZE (CSIZE),
    .ISIZE (ISIZE)
  ) u_ifid_reg (
    .clk_i    (clk),
    .reset_i  (reset),
    .stall_i  (stall),
    .squash_i (squash_s),
    .instr_i  (imem_rdata),
    .pcplus_i (pc_plus_in),
    .instr_o  (ifid_instr),
    .pcplus_o (ifid_pcplus),
    .valid_o  (ifid_valid)
  );

  assign pc_out       = pc_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus randomized run against a model.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target, pc_plus_in, imem_rdata;
  logic [31:0] pc_out, ifid_instr, ifid_pcplus;
  logic        ifid_valid;
  logic [15:0] redirect_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pcplus;
  logic        m_valid;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  // External incrementer and instruction memory: imem[k] = 0x1000_0000 + k
  assign pc_plus_in = pc_out + 32'd1;
  assign imem_rdata = 32'h1000_0000 + pc_out;

  pc_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc_plus_in    (pc_plus_in),
    .imem_rdata    (imem_rdata),
    .pc_out        (pc_out),
    .ifid_instr    (ifid_instr),
    .ifid_pcplus   (ifid_pcplus),
    .ifid_valid    (ifid_valid),
    .redirect_cnt  (redirect_cnt)
  );

  task automatic drive(input logic rst, input logic st, input logic fl, input logic br,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt);
    reset = rst; stall = st; flush = fl;
    branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'd0; m_instr = 32'd0; m_pcplus = 32'd0; m_valid = 1'b0; m_cnt = 16'd0;
    end else begin
      if (fl || j || br) begin
        m_instr = 32'd0; m_pcplus = 32'd0; m_valid = 1'b0;
      end else if (!st) begin
        m_instr = 32'h1000_0000 + m_pc; m_pcplus = m_pc + 32'd1; m_valid = 1'b1;
      end
      if (j) m_pc = jt;
      else if (br) m_pc = bt;
      else if (!st) m_pc = m_pc + 32'd1;
      if ((j || br) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++;
    if (pc_out !== 32'd0 || ifid_instr !== 32'd0 || ifid_pcplus !== 32'd0 ||
        ifid_valid !== 1'b0 || redirect_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: pc=%h instr=%h pcplus=%h valid=%b cnt=%h, required all zero",
               pc_out, ifid_instr, ifid_pcplus, ifid_valid, redirect_cnt);
    end
  endtask

  task automatic test_free_run_stall_branch_jump;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      checks++;
      if (pc_out !== 32'(k) || ifid_instr !== 32'h1000_0000 + 32'(k - 1) ||
          ifid_pcplus !== 32'(k) || ifid_valid !== 1'b1) begin
        errors++;
        $display("FAIL free_run k=%0d: pc=%h instr=%h pcplus=%h valid=%b", k, pc_out,
                 ifid_instr, ifid_pcplus, ifid_valid);
      end
    end
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      checks++;
      if (pc_out !== 32'd5 || ifid_instr !== 32'h1000_0004 || ifid_pcplus !== 32'd5 ||
          ifid_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold %0d: pc=%h instr=%h pcplus=%h, required 5/10000004/5",
                 s, pc_out, ifid_instr, ifid_pcplus);
      end
    end
    idle(1);
    checks++;
    if (pc_out !== 32'd6 || ifid_instr !== 32'h1000_0005 || ifid_pcplus !== 32'd6) begin
      errors++;
      $display("FAIL stall_release: pc=%h instr=%h pcplus=%h, required 6/10000005/6",
               pc_out, ifid_instr, ifid_pcplus);
    end
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
    checks++;
    if (pc_out !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0 ||
        ifid_pcplus !== 32'd0 || redirect_cnt !== 16'd1) begin
      errors++;
      $display("FAIL branch: pc=%h valid=%b instr=%h pcplus=%h cnt=%h, required 40/0/0/0/1",
               pc_out, ifid_valid, ifid_instr, ifid_pcplus, redirect_cnt);
    end
    idle(1);
    checks++;
    if (ifid_instr !== 32'h1000_0040 || ifid_pcplus !== 32'h41 || ifid_valid !== 1'b1 ||
        pc_out !== 32'h41) begin
      errors++;
      $display("FAIL after_branch: instr=%h pcplus=%h valid=%b pc=%h, required 10000040/41/1/41",
               ifid_instr, ifid_pcplus, ifid_valid, pc_out);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
    checks++;
    if (pc_out !== 32'h80 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0 ||
        redirect_cnt !== 16'd2) begin
      errors++;
      $display("FAIL jump_branch_stall: pc=%h valid=%b instr=%h cnt=%h, required 80/0/0/2",
               pc_out, ifid_valid, ifid_instr, redirect_cnt);
    end
  endtask

  task automatic test_flush_and_reset;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(10);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++;
    if (pc_out !== 32'd11 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0 ||
        redirect_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flush: pc=%h valid=%b instr=%h cnt=%h, required 11/0/0/0",
               pc_out, ifid_valid, ifid_instr, redirect_cnt);
    end
    idle(1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++;
    if (pc_out !== 32'd12 || ifid_valid !== 1'b0 || ifid_pcplus !== 32'd0) begin
      errors++;
      $display("FAIL flush_stall: pc=%h valid=%b pcplus=%h, required c/0/0",
               pc_out, ifid_valid, ifid_pcplus);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h55);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h99);
    checks++;
    if (pc_out !== 32'd0 || ifid_instr !== 32'd0 || ifid_pcplus !== 32'd0 ||
        ifid_valid !== 1'b0 || redirect_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_during_jump: pc=%h instr=%h pcplus=%h valid=%b cnt=%h",
               pc_out, ifid_instr, ifid_pcplus, ifid_valid, redirect_cnt);
    end
  endtask

  task automatic test_wrap_and_saturate;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    checks++;
    if (pc_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_jump: pc=%h, required ffffffff", pc_out);
    end
    idle(1);
    checks++;
    if (pc_out !== 32'd0 || ifid_instr !== 32'h0FFF_FFFF || ifid_pcplus !== 32'd0 ||
        ifid_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap: pc=%h instr=%h pcplus=%h valid=%b, required 0/0fffffff/0/1",
               pc_out, ifid_instr, ifid_pcplus, ifid_valid);
    end
    // already 1 redirect; 65533 more brings the count to 0xFFFE
    for (int i = 0; i < 65533; i++) begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b1;
      jump_target = 32'h100;
      @(posedge clk);
    end
    #1;
    checks++;
    if (redirect_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL cnt_near_max: cnt=%h, required fffe", redirect_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
      checks++;
      if (redirect_cnt !== 16'hFFFF || pc_out !== 32'h200) begin
        errors++;
        $display("FAIL cnt_saturate %0d: cnt=%h pc=%h, required ffff/200", i, redirect_cnt,
                 pc_out);
      end
    end
  endtask

  task automatic test_random;
    logic        r_rst, r_st, r_fl, r_br, r_j;
    logic [31:0] r_bt, r_jt;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int c = 0; c < 400; c++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_fl  = ($urandom_range(0, 7) == 0);
      r_br  = ($urandom_range(0, 7) == 0);
      r_j   = ($urandom_range(0, 9) == 0);
      r_bt  = $urandom;
      r_jt  = $urandom;
      drive(r_rst, r_st, r_fl, r_br, r_bt, r_j, r_jt);
      checks++;
      if (pc_out !== m_pc || ifid_instr !== m_instr || ifid_pcplus !== m_pcplus ||
          ifid_valid !== m_valid || redirect_cnt !== m_cnt) begin
        errors++;
        $display("FAIL random c=%0d: got pc=%h instr=%h pcplus=%h valid=%b cnt=%h, required %h %h %h %b %h",
                 c, pc_out, ifid_instr, ifid_pcplus, ifid_valid, redirect_cnt,
                 m_pc, m_instr, m_pcplus, m_valid, m_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'd0; jump_target = 32'd0;
    m_pc = 32'd0; m_instr = 32'd0; m_pcplus = 32'd0; m_valid = 1'b0; m_cnt = 16'd0;
    test_reset;
    test_free_run_stall_branch_jump;
    test_flush_and_reset;
    test_wrap_and_saturate;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the program counter and drives it to instruction memory and to the pcplus incrementer.
- Selects the next PC from the pcplus result, a branch target or a jump target.
- Registers the fetched instruction and PC+1 into the IF/ID pipeline register, with hazard-unit stall and flush control.

Parameters:
- CSIZE, 31, MSB index of PC/address buses (width CSIZE+1); word-addressed, PC increments by 1.
- ISIZE, 31, MSB index of instruction word (width ISIZE+1).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high; clears PC and IF/ID.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  squash the IF/ID entry (insert bubble).
- branch_taken  input  1  branch resolved taken this cycle.
- branch_target  input  CSIZE+1  branch destination.
- jump  input  1  jump this cycle.
- jump_target  input  CSIZE+1  jump destination.
- pc_plus_in  input  CSIZE+1  pcplus result (pc_out+1).
- imem_rdata  input  ISIZE+1  instruction at pc_out (combinational read).
- pc_out  output  CSIZE+1  current PC, to imem and pcplus.
- ifid_instr  output  ISIZE+1  registered instruction.
- ifid_pcplus  output  CSIZE+1  registered PC+1.
- ifid_valid  output  1  1 = IF/ID holds a real instruction.
- redirect_cnt  output  16  count of taken redirects (jump or branch), saturating.

Behaviour:
- All state updates on the rising clk edge; no asynchronous paths.
- Reset (highest priority):
  - pc_out = RESET_PC.
  - ifid_instr = NOP (all zeros).
  - ifid_pcplus = 0.
  - ifid_valid = 0.
  - redirect_cnt = 0.
- redirect = jump | branch_taken.
- Next PC priority:
  - jump → jump_target.
  - else branch_taken → branch_target.
  - else stall → hold pc_out.
  - else → pc_plus_in.
  - A redirect overrides stall.
  - Jump wins if jump and branch_taken are asserted together.
- IF/ID priority:
  - flush or redirect → bubble: ifid_instr = NOP, ifid_pcplus = 0, ifid_valid = 0. Applies even when stall is high.
  - else stall → hold all IF/ID fields.
  - else → capture imem_rdata and pc_plus_in, set ifid_valid = 1.
- Latency: instruction at PC n appears on ifid_instr one edge after pc_out = n, provided neither stall nor squash is active.
- First cycle after reset deasserts: PC = RESET_PC. Next edge (no stall): IF/ID holds instr@RESET_PC, ifid_pcplus = RESET_PC+1, ifid_valid = 1.
- Wrap-around: PC wraps modulo 2^(CSIZE+1) via pc_plus_in; no special handling.
- redirect_cnt: +1 on each edge where redirect=1 and reset=0; saturates at 16'hFFFF.
- Outputs are registered only; pc_out feeds pcplus combinationally with no loop inside this block.
- Reset mid-stall or mid-redirect: reset wins and the redirect is discarded.

Decomposition:
- Shared package: NOP_INSTR (all-zero sll $0), RESET_PC default, PC/instruction width constants.
- Sub-module ifid_reg: IF/ID register with stall/squash. Instantiated once.
- PC register, next-PC mux and counter stay at top level.

Test Plan:
- Reset then free run, imem[k] = 32'h1000_0000+k → pc_out 0,1,2,3 on successive cycles; ifid_instr 0x10000000 with ifid_pcplus 1 and valid 1 one cycle after pc 0.
- stall high for 3 cycles at pc 5 → pc_out stays 5; IF/ID stays instr@4, pcplus 5. On release, pc 6 and IF/ID instr@5.
- branch_taken with target 0x40 at pc 8 → next pc_out 0x40, ifid_valid 0, ifid_instr 0; following cycle IF/ID instr@0x40, pcplus 0x41; redirect_cnt 1.
- jump (target 0x80) and branch_taken (target 0x40) same cycle while stall high → pc_out 0x80, bubble inserted, redirect_cnt +1.
- flush alone at pc 10 → pc_out 11, ifid_valid 0. Reset asserted during a jump → pc_out 0, all IF/ID fields 0, redirect_cnt 0.
- Force pc_out to max value 2^(CSIZE+1)-1 via jump, then run → pc_out wraps to 0. Force redirect_cnt to 0xFFFF, apply a branch → count stays 0xFFFF.
